// File: rtl/fwd_pkg.sv
// Shared types and constants for the decode-stage forwarding tracker.
// Load-use stall generation is enabled by defining FWD_LOAD_STALL_EN.
package fwd_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned REG_W       = 3;
  localparam int unsigned STALL_CNT_W = 16;

  // Width of one slot field in Forwarding_vector: {valid, reg}
  localparam int unsigned SLOT_FW_W = REG_W + 1;
  localparam int unsigned EX_OFF    = 0;
  localparam int unsigned MEM_OFF   = 4;
  localparam int unsigned WB_OFF    = 8;
  localparam int unsigned VEC_W     = 3 * SLOT_FW_W;

  typedef struct packed {
    logic             valid;
    logic             load;
    logic [REG_W-1:0] regsel;
  } fwd_slot_t;

  localparam fwd_slot_t FWD_BUBBLE = '{valid: 1'b0, load: 1'b0, regsel: '0};

  // Packs a slot into its forwarding field; EX hides loads whose data is not ready yet.
  function automatic logic [SLOT_FW_W-1:0] fwd_field(fwd_slot_t s, logic mask_load);
    return {s.valid & ~(mask_load & s.load), s.regsel};
  endfunction

endpackage

// File: rtl/fwd_tracker_if.sv
// Decode/pipeline-facing bus of the forwarding tracker.
// master = pipeline/decode side, slave = fwd_tracker.
interface fwd_tracker_if;
  import fwd_pkg::*;

  logic [REG_W-1:0]       Dec_write_reg;
  logic                   Dec_regwrite;
  logic                   Dec_validfwd;
  logic                   Dec_memread;
  logic [REG_W-1:0]       Dec_read1_sel;
  logic [REG_W-1:0]       Dec_read2_sel;
  logic                   Dec_read1_used;
  logic                   Dec_read2_used;
  logic                   Stall_in;
  logic                   Flush;
  logic [DATA_W-1:0]      Ex_result;
  logic [DATA_W-1:0]      Mem_result;
  logic [DATA_W-1:0]      Wb_result;
  logic [VEC_W-1:0]       Forwarding_vector;
  logic [3*DATA_W-1:0]    Forwarding_data;
  logic                   Load_use_stall;
  logic [STALL_CNT_W-1:0] Stall_count;
  logic                   err;

  modport master (
    output Dec_write_reg, Dec_regwrite, Dec_validfwd, Dec_memread,
           Dec_read1_sel, Dec_read2_sel, Dec_read1_used, Dec_read2_used,
           Stall_in, Flush, Ex_result, Mem_result, Wb_result,
    input  Forwarding_vector, Forwarding_data, Load_use_stall, Stall_count, err
  );

  modport slave (
    input  Dec_write_reg, Dec_regwrite, Dec_validfwd, Dec_memread,
           Dec_read1_sel, Dec_read2_sel, Dec_read1_used, Dec_read2_used,
           Stall_in, Flush, Ex_result, Mem_result, Wb_result,
    output Forwarding_vector, Forwarding_data, Load_use_stall, Stall_count, err
  );

endinterface

// File: rtl/fwd_slot.sv
// One pipeline slot register: sync reset, hold enable, bubble insertion.
module fwd_slot
  import fwd_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      hold,
  input  logic      bubble,
  input  fwd_slot_t slot_in,
  output fwd_slot_t slot_q
);

  fwd_slot_t slot_d;

  always_comb begin
    slot_d = slot_q;
    if (!hold) begin
      slot_d = bubble ? FWD_BUBBLE : slot_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= FWD_BUBBLE;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/fwd_tracker.sv
// Tracks in-flight register writes through EX/MEM/WB and drives forwarding info to decode.
// Optional load-use stall and stall counter enabled by FWD_LOAD_STALL_EN.
module fwd_tracker
  import fwd_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fwd_tracker_if.slave  bus
);

  fwd_slot_t dec_entry_c;
  fwd_slot_t ex_q;
  fwd_slot_t mem_q;
  fwd_slot_t wb_q;
  logic      load_use_stall_c;
  logic      ex_bubble_c;

  always_comb begin
    dec_entry_c = '{valid:  bus.Dec_regwrite & bus.Dec_validfwd,
                    load:   bus.Dec_memread,
                    regsel: bus.Dec_write_reg};
  end

  // Stall and flush both replace the decode entry with a bubble; Stall_in overrides via hold.
  assign ex_bubble_c = load_use_stall_c | bus.Flush;

  fwd_slot u_ex (
    .clk     (clk),
    .rst     (rst),
    .hold    (bus.Stall_in),
    .bubble  (ex_bubble_c),
    .slot_in (dec_entry_c),
    .slot_q  (ex_q)
  );

  fwd_slot u_mem (
    .clk     (clk),
    .rst     (rst),
    .hold    (bus.Stall_in),
    .bubble  (1'b0),
    .slot_in (ex_q),
    .slot_q  (mem_q)
  );

  fwd_slot u_wb (
    .clk     (clk),
    .rst     (rst),
    .hold    (bus.Stall_in),
    .bubble  (1'b0),
    .slot_in (mem_q),
    .slot_q  (wb_q)
  );

`ifdef FWD_LOAD_STALL_EN
  logic                   src_hit_c;
  logic [STALL_CNT_W-1:0] stall_count_q;
  logic [STALL_CNT_W-1:0] stall_count_d;

  always_comb begin
    src_hit_c = (bus.Dec_read1_used & (bus.Dec_read1_sel == ex_q.regsel)) |
                (bus.Dec_read2_used & (bus.Dec_read2_sel == ex_q.regsel));
    load_use_stall_c = ex_q.valid & ex_q.load & ~bus.Flush & src_hit_c;
  end

  // Saturating count of stall cycles actually taken (frozen cycles do not count).
  always_comb begin
    stall_count_d = stall_count_q;
    if (load_use_stall_c && !bus.Stall_in && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.Stall_count = stall_count_q;
`else
  logic unused_dec_src;

  assign load_use_stall_c = 1'b0;
  assign bus.Stall_count  = '0;
  assign unused_dec_src   = ^{bus.Dec_read1_sel, bus.Dec_read2_sel,
                              bus.Dec_read1_used, bus.Dec_read2_used};
`endif

  always_comb begin
    bus.Forwarding_vector = '0;
    bus.Forwarding_vector[EX_OFF  +: SLOT_FW_W] = fwd_field(ex_q,  1'b1);
    bus.Forwarding_vector[MEM_OFF +: SLOT_FW_W] = fwd_field(mem_q, 1'b0);
    bus.Forwarding_vector[WB_OFF  +: SLOT_FW_W] = fwd_field(wb_q,  1'b0);
  end

  assign bus.Forwarding_data = {bus.Wb_result, bus.Mem_result, bus.Ex_result};
  assign bus.Load_use_stall  = load_use_stall_c;
  assign bus.err             = bus.Stall_in & bus.Flush;

endmodule

// File: tb/tb_fwd_tracker.sv
// Scoreboard bench for fwd_tracker: directed spec scenarios then randomized traffic
// against a queue-level pipeline model. Honours FWD_LOAD_STALL_EN like the design.
module tb_fwd_tracker;
  import fwd_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_tracker_if bus ();

  fwd_tracker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  wr;
    logic        regwrite, validfwd, memread;
    logic [2:0]  s1, s2;
    logic        u1, u2, stall_in, flush;
    logic [15:0] ex, mem, wb;
  } stim_t;

  typedef struct {
    bit          chk;
    logic [11:0] vec;
    logic [47:0] data;
    logic        lus;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  typedef struct {
    bit v;
    bit ld;
    int r;
  } ent_t;

  exp_t sbq[$];
  ent_t pipe[3];          // 0 = EX, 1 = MEM, 2 = WB
  int   cnt_m;
  bit   model_known = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, wr: 3'd0, regwrite: 1'b0, validfwd: 1'b0, memread: 1'b0,
          s1: 3'd0, s2: 3'd0, u1: 1'b0, u2: 1'b0, stall_in: 1'b0, flush: 1'b0,
          ex: 16'h0, mem: 16'h0, wb: 16'h0};
    return s;
  endfunction

  function automatic int slot_bits(ent_t e, bit mask_load);
    return ((e.v && !(mask_load && e.ld)) ? 8 : 0) + e.r;
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  // Drives one cycle, pushes the expected outputs, then advances the model past the edge.
  task automatic step(input stim_t s, input bit use_const, input logic [11:0] cvec);
    exp_t e;
    bit   lus;
    @(negedge clk);
    rst                = s.rst;
    bus.Dec_write_reg  = s.wr;
    bus.Dec_regwrite   = s.regwrite;
    bus.Dec_validfwd   = s.validfwd;
    bus.Dec_memread    = s.memread;
    bus.Dec_read1_sel  = s.s1;
    bus.Dec_read2_sel  = s.s2;
    bus.Dec_read1_used = s.u1;
    bus.Dec_read2_used = s.u2;
    bus.Stall_in       = s.stall_in;
    bus.Flush          = s.flush;
    bus.Ex_result      = s.ex;
    bus.Mem_result     = s.mem;
    bus.Wb_result      = s.wb;

    lus = 1'b0;
`ifdef FWD_LOAD_STALL_EN
    lus = pipe[0].v && pipe[0].ld && !s.flush &&
          ((s.u1 && int'(s.s1) == pipe[0].r) || (s.u2 && int'(s.s2) == pipe[0].r));
`endif
    e.chk  = model_known;
    e.vec  = 12'(slot_bits(pipe[2], 1'b0) * 256 + slot_bits(pipe[1], 1'b0) * 16 +
                 slot_bits(pipe[0], 1'b1));
    if (use_const) e.vec = cvec;
    e.data = {s.wb, s.mem, s.ex};
    e.lus  = lus;
    e.cnt  = 16'(cnt_m);
    e.err  = s.stall_in && s.flush;
    sbq.push_back(e);

    if (s.rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, ld: 1'b0, r: 0};
      cnt_m       = 0;
      model_known = 1'b1;
    end else if (!s.stall_in) begin
      if (lus && cnt_m < 65535) cnt_m++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (lus || s.flush) pipe[0] = '{v: 1'b0, ld: 1'b0, r: 0};
      else pipe[0] = '{v: s.regwrite && s.validfwd, ld: s.memread, r: int'(s.wr)};
    end
  endtask

  // Monitor: every cycle the DUT presents outputs; compare against the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() == 0) continue;
      e = sbq.pop_front();
      if (!e.chk) continue;
      check("vector", 48'(bus.Forwarding_vector), 48'(e.vec));
      check("data",   bus.Forwarding_data,        e.data);
      check("stall",  48'(bus.Load_use_stall),    48'(e.lus));
      check("count",  48'(bus.Stall_count),       48'(e.cnt));
      check("err",    48'(bus.err),               48'(e.err));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, ld: 1'b0, r: 0};
    cnt_m = 0;

    // Reset, then idle
    s = idle(); s.rst = 1'b1;
    step(s, 1'b0, 12'h000);
    step(s, 1'b1, 12'h000);
    s = idle();
    step(s, 1'b1, 12'h000);

    // Single write to r3 walks EX -> MEM -> WB -> gone
    s = idle(); s.wr = 3'd3; s.regwrite = 1'b1; s.validfwd = 1'b1;
    step(s, 1'b1, 12'h000);
    s = idle(); s.ex = 16'hBEEF;
    step(s, 1'b1, 12'h00B);
    s = idle();
    step(s, 1'b1, 12'h0B0);
    step(s, 1'b1, 12'hB00);
    step(s, 1'b1, 12'h000);

    // Load r2 followed by a reader of r2; decode re-presents the reader
    s = idle(); s.wr = 3'd2; s.regwrite = 1'b1; s.validfwd = 1'b1; s.memread = 1'b1;
    step(s, 1'b1, 12'h000);
    s = idle(); s.s1 = 3'd2; s.u1 = 1'b1;
    step(s, 1'b1, 12'h002);
    step(s, 1'b1, 12'h0A0);
    s = idle();
    repeat (3) step(s, 1'b0, 12'h000);

    // Write r5 then freeze two cycles
    s = idle(); s.wr = 3'd5; s.regwrite = 1'b1; s.validfwd = 1'b1;
    step(s, 1'b1, 12'h000);
    s = idle(); s.stall_in = 1'b1;
    step(s, 1'b1, 12'h00D);
    step(s, 1'b1, 12'h00D);
    s = idle();
    step(s, 1'b1, 12'h00D);

    // Flush squashes the r6 write while MEM moves into WB
    s = idle(); s.wr = 3'd6; s.regwrite = 1'b1; s.validfwd = 1'b1; s.flush = 1'b1;
    step(s, 1'b1, 12'h0D0);
    s = idle(); s.wr = 3'd7; s.regwrite = 1'b1; s.validfwd = 1'b1;
    step(s, 1'b1, 12'hD00);

    // Flush together with Stall_in: err, everything holds
    s = idle(); s.stall_in = 1'b1; s.flush = 1'b1;
    step(s, 1'b1, 12'h00F);
    s = idle();
    step(s, 1'b1, 12'h00F);
    step(s, 1'b1, 12'h0F0);

    // Randomized traffic, including occasional reset mid-activity
    repeat (1500) begin
      s.rst      = ($urandom_range(0, 63) == 0);
      s.wr       = 3'($urandom_range(0, 7));
      s.regwrite = ($urandom_range(0, 3) != 0);
      s.validfwd = ($urandom_range(0, 3) != 0);
      s.memread  = ($urandom_range(0, 2) == 0);
      s.s1       = 3'($urandom_range(0, 7));
      s.s2       = 3'($urandom_range(0, 7));
      s.u1       = ($urandom_range(0, 1) == 1);
      s.u2       = ($urandom_range(0, 1) == 1);
      s.stall_in = ($urandom_range(0, 7) == 0);
      s.flush    = ($urandom_range(0, 7) == 0);
      s.ex       = 16'($urandom);
      s.mem      = 16'($urandom);
      s.wb       = 16'($urandom);
      step(s, 1'b0, 12'h000);
    end

    s = idle();
    repeat (2) step(s, 1'b0, 12'h000);
    @(negedge clk);
    #4;
    check("queue_drained", 48'(sbq.size()), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
